mtsp_dst_operate: RTL and testbench

Destination-side result modifier for the MTSP core: the writeback counterpart of the per-operand source negate stage. It takes each 32-bit ALU result (integer, or 24-bit float with an 8-bit tag in [31:24]) and applies the destination modifier: absolute, negate, then saturate. It forwards the modified result to the register-file write port through a 2-stage elastic valid/ready pipeline.

---
 rtl/mtsp_dst_pkg.sv | 43 ++++
 rtl/mtsp_dst_modify1d.sv | 63 ++++++
 rtl/mtsp_dst_operate.sv | 89 ++++++++
 tb/tb_mtsp_dst_operate.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtsp_dst_pkg.sv
// Shared definitions for the MTSP destination-modifier path.
package mtsp_dst_pkg;

   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned OP_WIDTH     = 4;

   // Destination modifier bit positions.
   localparam int unsigned DSTOP_SELECT = 0;
   localparam int unsigned DSTOP_NEGATE = 1;
   localparam int unsigned DSTOP_ABS    = 2;
   localparam int unsigned DSTOP_SAT    = 3;

   // fp24 field layout; bits above the fp24 word carry a tag.
   localparam int unsigned FP_SIGN      = 23;
   localparam int unsigned FP_EXP_HI    = 22;
   localparam int unsigned FP_EXP_LO    = 16;
   localparam int unsigned FP_MANT_HI   = 15;
   localparam int unsigned FP_MANT_LO   = 0;
   localparam int unsigned FP_EXP_WIDTH = FP_EXP_HI - FP_EXP_LO + 1;
   localparam int unsigned FP_MANT_WIDTH = FP_MANT_HI - FP_MANT_LO + 1;
   localparam int unsigned FP_TAG_LO    = 24;

   // Biased exponent of 1.0.
   localparam logic [FP_EXP_WIDTH-1:0] FP_ONE_EXP = 7'h3F;

   // Occupancy of one pipeline stage.
   typedef enum logic {
      STAGE_EMPTY = 1'b0,
      STAGE_FULL  = 1'b1
   } stage_state_t;

   // Stage-1 payload: the modifier and the raw result.
   typedef struct packed {
      logic [OP_WIDTH-1:0]   op;
      logic [DATA_WIDTH-1:0] data;
   } dst_payload_t;

   // Two's-complement negative modulo 2^32.
   function automatic logic [DATA_WIDTH-1:0] twos_negate(input logic [DATA_WIDTH-1:0] x);
      return DATA_WIDTH'(~x + DATA_WIDTH'(1));
   endfunction

endpackage

// File: rtl/mtsp_dst_modify1d.sv
// Combinational destination modifier: ABS, then NEGATE, then SAT, for integer or fp24.
module mtsp_dst_modify1d
   import mtsp_dst_pkg::*;
(
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0]    int_abs;
   logic [DATA_WIDTH-1:0]    int_neg;
   logic [DATA_WIDTH-1:0]    int_res;
   logic                     fp_sign;
   logic [FP_EXP_WIDTH-1:0]  fp_exp;
   logic [FP_MANT_WIDTH-1:0] fp_mant;
   logic [DATA_WIDTH-1:0]    fp_res;

   // Integer path: wrap-around abs/negate, then clamp negatives to zero.
   always_comb begin
      int_abs = data_in;
      if (op[DSTOP_ABS] && data_in[DATA_WIDTH-1]) begin
         int_abs = twos_negate(data_in);
      end
      int_neg = int_abs;
      if (op[DSTOP_NEGATE]) begin
         int_neg = twos_negate(int_abs);
      end
      int_res = int_neg;
      if (op[DSTOP_SAT] && int_neg[DATA_WIDTH-1]) begin
         int_res = '0;
      end
   end

   // fp24 path: sign-only abs/negate, then clamp to [0.0, 1.0]; the tag byte passes through.
   always_comb begin
      fp_exp  = data_in[FP_EXP_HI:FP_EXP_LO];
      fp_mant = data_in[FP_MANT_HI:FP_MANT_LO];
      fp_sign = data_in[FP_SIGN];
      if (op[DSTOP_ABS]) begin
         fp_sign = 1'b0;
      end
      if (op[DSTOP_NEGATE]) begin
         fp_sign = ~fp_sign;
      end
      fp_res = {data_in[DATA_WIDTH-1:FP_TAG_LO], fp_sign, fp_exp, fp_mant};
      if (op[DSTOP_SAT]) begin
         if (fp_sign) begin
            fp_res[FP_SIGN:0] = '0;
         end else if (fp_exp >= FP_ONE_EXP) begin
            fp_res[FP_EXP_HI:0] = {FP_ONE_EXP, {FP_MANT_WIDTH{1'b0}}};
         end
      end
   end

   // Result select by operand type.
   always_comb begin
      data_out = fp_res;
      if (op[DSTOP_SELECT]) begin
         data_out = int_res;
      end
   end

endmodule

// File: rtl/mtsp_dst_operate.sv
// Destination-side result modifier with a 2-stage elastic valid/ready pipeline.
module mtsp_dst_operate
   import mtsp_dst_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = 6
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [OP_WIDTH-1:0]    IN_OP,
   input  logic [INDEX_WIDTH-1:0] IN_INDEX,
   input  logic [DATA_WIDTH-1:0]  IN_DATA,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [INDEX_WIDTH-1:0] OUT_INDEX,
   output logic [DATA_WIDTH-1:0]  OUT_DATA,
   output logic                   BUSY
);

   stage_state_t           s1_state;
   stage_state_t           s2_state;
   dst_payload_t           s1_payload;
   logic [INDEX_WIDTH-1:0] s1_index;
   logic [DATA_WIDTH-1:0]  mod_data;
   logic                   s1_adv;
   logic                   accept;

   // Handshake decode: S1 moves on when S2 is empty or draining.
   always_comb begin
      s1_adv   = (s1_state == STAGE_FULL) && ((s2_state == STAGE_EMPTY) || OUT_READY);
      IN_READY = (s1_state == STAGE_EMPTY) || s1_adv;
      accept   = IN_VALID && IN_READY;
   end

   // Per-stage occupancy state machine.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_state <= STAGE_EMPTY;
         s2_state <= STAGE_EMPTY;
      end else begin
         case (s1_state)
            STAGE_EMPTY: if (accept) s1_state <= STAGE_FULL;
            STAGE_FULL:  if (s1_adv && !accept) s1_state <= STAGE_EMPTY;
            default:     s1_state <= STAGE_EMPTY;
         endcase
         case (s2_state)
            STAGE_EMPTY: if (s1_adv) s2_state <= STAGE_FULL;
            STAGE_FULL:  if (OUT_READY && !s1_adv) s2_state <= STAGE_EMPTY;
            default:     s2_state <= STAGE_EMPTY;
         endcase
      end
   end

   // Stage-1 capture of the raw result on accept only.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_payload <= '0;
         s1_index   <= '0;
      end else if (accept) begin
         s1_payload <= '{op: IN_OP, data: IN_DATA};
         s1_index   <= IN_INDEX;
      end
   end

   mtsp_dst_modify1d u_modify (
      .op       (s1_payload.op),
      .data_in  (s1_payload.data),
      .data_out (mod_data)
   );

   // Stage-2 capture of the modified result on advance only; holds while stalled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_DATA  <= '0;
         OUT_INDEX <= '0;
      end else if (s1_adv) begin
         OUT_DATA  <= mod_data;
         OUT_INDEX <= s1_index;
      end
   end

   // Status outputs taken straight from the stage state flops.
   always_comb begin
      OUT_VALID = (s2_state == STAGE_FULL);
      BUSY      = (s1_state == STAGE_FULL) || (s2_state == STAGE_FULL);
   end

endmodule

// File: tb/tb_mtsp_dst_operate.sv
// Self-checking bench for mtsp_dst_operate: directed cases, backpressure, reset, random traffic.
module tb_mtsp_dst_operate;

   localparam int unsigned IW     = 6;
   localparam int          N_RAND = 10000;

   logic          CLK;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [3:0]    IN_OP;
   logic [IW-1:0] IN_INDEX;
   logic [31:0]   IN_DATA;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [IW-1:0] OUT_INDEX;
   logic [31:0]   OUT_DATA;
   logic          BUSY;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   typedef struct {
      logic [IW-1:0] index;
      logic [31:0]   data;
   } exp_t;

   exp_t          q[$];
   logic          prev_stall = 1'b0;
   logic [31:0]   prev_data;
   logic [IW-1:0] prev_index;

   mtsp_dst_operate #(.INDEX_WIDTH(IW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_OP     (IN_OP),
      .IN_INDEX  (IN_INDEX),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_INDEX (OUT_INDEX),
      .OUT_DATA  (OUT_DATA),
      .BUSY      (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference: the modifier rules evaluated on numbers and fields.
   function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] d);
      int          v;
      logic        s;
      int unsigned e;
      if (op[0]) begin
         v = $signed(d);
         if (op[2] && v < 0) v = -v;
         if (op[1]) v = -v;
         if (op[3] && v < 0) v = 0;
         return 32'(v);
      end
      s = d[23];
      e = 32'(d[22:16]);
      if (op[2]) s = 1'b0;
      if (op[1]) s = !s;
      if (op[3]) begin
         if (s) return {d[31:24], 24'h0};
         if (e >= 63) return {d[31:24], 1'b0, 7'd63, 16'h0};
      end
      return {d[31:24], s, d[22:0]};
   endfunction

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return {8'($urandom), 1'($urandom), 7'(62 + $urandom_range(0, 2)), 16'($urandom)};
         3: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard and handshake invariants, sampled mid-cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (RST) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         checks++;
         if (IN_READY !== (OUT_READY || q.size() < 2)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b (occ %0d)", IN_READY, (OUT_READY || q.size() < 2), q.size());
         end
         checks++;
         if (BUSY !== (q.size() != 0)) begin
            errors++;
            $display("FAIL busy: got %b want %b", BUSY, (q.size() != 0));
         end
         if (prev_stall) begin
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== prev_data || OUT_INDEX !== prev_index) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                        OUT_VALID, OUT_DATA, OUT_INDEX, prev_data, prev_index);
            end
         end
         if (OUT_VALID && OUT_READY) begin
            wr_count++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got d=%h i=%0d want no write", OUT_DATA, OUT_INDEX);
            end else begin
               e = q.pop_front();
               if (OUT_DATA !== e.data || OUT_INDEX !== e.index) begin
                  errors++;
                  $display("FAIL write_data: got d=%h i=%0d want d=%h i=%0d", OUT_DATA, OUT_INDEX, e.data, e.index);
               end
            end
         end
         if (IN_VALID && IN_READY) begin
            e.index = IN_INDEX;
            e.data  = ref_model(IN_OP, IN_DATA);
            q.push_back(e);
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_data  = OUT_DATA;
         prev_index = OUT_INDEX;
      end
   end

   task automatic test_reset();
      RST = 1'b1;
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      IN_OP = 4'h0;
      IN_INDEX = '0;
      IN_DATA = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1 || OUT_DATA !== 32'h0 || OUT_INDEX !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b b=%b r=%b d=%h i=%0d want 0 0 1 0 0",
                  OUT_VALID, BUSY, IN_READY, OUT_DATA, OUT_INDEX);
      end
      @(posedge CLK);
      #1 RST = 1'b0;
      OUT_READY = 1'b1;
   endtask

   task automatic test_directed();
      logic [3:0]  vop  [10] = '{4'b0011, 4'b0111, 4'b0010, 4'b1000, 4'b1000,
                                 4'b0101, 4'b1101, 4'b1001, 4'b0100, 4'b1100};
      logic [31:0] vin  [10] = '{32'h0000_0005, 32'hFFFF_FFFB, 32'h123F_0000, 32'hA540_0000, 32'h00BF_8000,
                                 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3CC0_1234, 32'h01BE_1234};
      logic [31:0] vexp [10] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h12BF_0000, 32'hA53F_0000, 32'h0000_0000,
                                 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h3C40_1234, 32'h013E_1234};
      for (int k = 0; k < 10; k++) begin
         @(posedge CLK);
         #1;
         IN_VALID  = 1'b1;
         IN_OP     = vop[k];
         IN_DATA   = vin[k];
         IN_INDEX  = IW'(k + 3);
         OUT_READY = 1'b1;
         @(posedge CLK);
         #1 IN_VALID = 1'b0;
         @(negedge CLK);
         checks++;
         if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL lat_n_%0d: got out_valid %b want 0", k, OUT_VALID);
         end
         @(negedge CLK);
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== vexp[k] || OUT_INDEX !== IW'(k + 3)) begin
            errors++;
            $display("FAIL directed_%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                     k, OUT_VALID, OUT_DATA, OUT_INDEX, vexp[k], k + 3);
         end
         @(negedge CLK);
         checks++;
         if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL drain_%0d: got v=%b b=%b want 0 0", k, OUT_VALID, BUSY);
         end
      end
   endtask

   task automatic test_back_to_back();
      int  sent = 0;
      int  base = wr_count;
      int  first_low = -1;
      int  c = 0;
      logic acc;
      while ((wr_count - base) < 8 && c < 60) begin
         @(posedge CLK);
         #1;
         OUT_READY = !(c >= 2 && c <= 5);
         IN_VALID  = (sent < 8);
         IN_OP     = 4'($urandom);
         IN_DATA   = rand_data();
         IN_INDEX  = IW'(sent + 20);
         @(negedge CLK);
         if (IN_VALID && !IN_READY && first_low < 0) first_low = sent;
         if (c == 5) begin
            checks++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
               errors++;
               $display("FAIL stall_full: got r=%b v=%b want r=0 v=1", IN_READY, OUT_VALID);
            end
         end
         if (c == 6) begin
            checks++;
            if (IN_READY !== 1'b1) begin
               errors++;
               $display("FAIL ready_return: got %b want 1", IN_READY);
            end
         end
         acc = IN_VALID && IN_READY;
         if (acc) sent++;
         c++;
      end
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      checks++;
      if (first_low !== 2) begin
         errors++;
         $display("FAIL accepts_before_stall: got %0d want 2", first_low);
      end
      checks++;
      if ((wr_count - base) !== 8 || sent !== 8) begin
         errors++;
         $display("FAIL b2b_count: got writes=%0d sent=%0d want 8 8", wr_count - base, sent);
      end
   endtask

   task automatic test_reset_midflight();
      int base;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      repeat (2) begin
         IN_OP    = 4'($urandom);
         IN_DATA  = rand_data();
         IN_INDEX = IW'($urandom);
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b1 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
         errors++;
         $display("FAIL prefill: got b=%b v=%b r=%b want 1 1 0", BUSY, OUT_VALID, IN_READY);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      IN_VALID = 1'b1;
      base = wr_count;
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
         errors++;
         $display("FAIL rst_flush: got v=%b b=%b r=%b want 0 0 1", OUT_VALID, BUSY, IN_READY);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (wr_count !== base || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_write: got writes=%0d busy=%b want 0 0", wr_count - base, BUSY);
      end
   endtask

   task automatic test_random();
      int  sent = 0;
      int  base = wr_count;
      int  cyc = 0;
      logic pending = 1'b0;
      while (((wr_count - base) < N_RAND) && cyc < 60000) begin
         @(posedge CLK);
         #1;
         OUT_READY = ($urandom_range(0, 9) < 7);
         if (!pending && sent < N_RAND && $urandom_range(0, 9) < 7) begin
            pending  = 1'b1;
            IN_OP    = 4'($urandom);
            IN_DATA  = rand_data();
            IN_INDEX = IW'($urandom);
         end
         IN_VALID = pending;
         @(negedge CLK);
         if (IN_VALID && IN_READY) begin
            pending = 1'b0;
            sent++;
         end
         cyc++;
      end
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
      checks++;
      if ((wr_count - base) !== N_RAND || q.size() !== 0) begin
         errors++;
         $display("FAIL random_complete: got writes=%0d left=%0d want %0d 0", wr_count - base, q.size(), N_RAND);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      repeat (2) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
